// File: rtl/activity_led_bank.sv
// rtl/activity_led_bank.sv - multi-channel activity LED blinker with fixed on/off phases
// Optional ACTIVITY_LED_EDGE_DETECT_EN turns each pulse input into a rising-edge event.
module activity_led_bank #(
  parameter int NUM_CH     = 8,
  parameter int PERIOD     = 62500000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] pulse,
  input  logic [NUM_CH-1:0] mask,
  input  logic [NUM_CH-1:0] force_on,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] busy
);

  localparam int COUNT_WIDTH = $clog2(PERIOD);
  localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(PERIOD - 1);

  generate
    if (PERIOD < 2) begin : g_bad_period
      $error("activity_led_bank: PERIOD must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BLINK_ON  = 2'd1,
    BLINK_OFF = 2'd2,
    ARM_OFF   = 2'd3
  } state_t;

  logic [NUM_CH-1:0] ev;

`ifdef ACTIVITY_LED_EDGE_DETECT_EN
  logic [NUM_CH-1:0] pulse_q;

  // Cleared in reset so a level already high at release still counts once.
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_q <= '0;
    end else begin
      pulse_q <= pulse;
    end
  end

  assign ev = pulse & ~pulse_q & ~mask;
`else
  assign ev = pulse & ~mask;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   lit_q, lit_d;
    logic                   led_q, busy_q;
    logic                   at_last;

    assign at_last = (count_q == LAST);

    always_comb begin
      state_d = state_q;
      count_d = count_q;
      lit_d   = lit_q;
      case (state_q)
        IDLE: begin
          if (ev[i]) begin
            count_d = '0;
            lit_d   = 1'b1;
            state_d = BLINK_ON;
          end
        end
        BLINK_ON: begin
          if (at_last) begin
            count_d = '0;
            lit_d   = 1'b0;
            state_d = BLINK_OFF;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        BLINK_OFF: begin
          if (at_last) begin
            count_d = '0;
            if (ev[i]) begin
              lit_d   = 1'b1;
              state_d = BLINK_ON;
            end else begin
              state_d = IDLE;
            end
          end else begin
            count_d = count_q + 1'b1;
            if (ev[i]) begin
              state_d = ARM_OFF;
            end
          end
        end
        ARM_OFF: begin
          if (at_last) begin
            count_d = '0;
            lit_d   = 1'b1;
            state_d = BLINK_ON;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        default: begin
          count_d = '0;
          lit_d   = 1'b0;
          state_d = IDLE;
        end
      endcase
    end

    // Outputs come from next-state values so led/busy change the cycle after the event.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        count_q <= '0;
        lit_q   <= 1'b0;
        led_q   <= ACTIVE_LOW;
        busy_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        count_q <= count_d;
        lit_q   <= lit_d;
        led_q   <= (lit_d | force_on[i]) ^ ACTIVE_LOW;
        busy_q  <= (state_d != IDLE);
      end
    end

    assign led[i]  = led_q;
    assign busy[i] = busy_q;
  end

endmodule
